// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU state encoding and data width constants.
package alu_pkg;

    localparam int ALU_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_seq.sv
// mul_seq: shift-add multiplier, one multiplier bit per clock, start/busy/done handshake.
// Define SIGNED_MUL_EN for two's complement operands (magnitude multiply, sign fix on exit).
module mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_DW / 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [WIDTH-1:0] mplr_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    sum_d;
    logic [PW-1:0]    res_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;

    assign sum_d = acc_q + (mplr_q[0] ? mcand_q : '0);

`ifdef SIGNED_MUL_EN
    logic sign_q;
    // -2^(WIDTH-1) negates to itself, which is exactly its unsigned magnitude
    assign a_d   = a[WIDTH-1] ? -a : a;
    assign b_d   = b[WIDTH-1] ? -b : b;
    assign res_d = sign_q ? -sum_d : sum_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sign_q <= 1'b0;
        else if (state_q == ST_IDLE && start)
            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
    end
`else
    assign a_d   = a;
    assign b_d   = b;
    assign res_d = sum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand_q <= {{WIDTH{1'b0}}, a_d};
                        mplr_q  <= b_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q   <= sum_d;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        product <= res_d;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench for mul_seq; expected products queued at start, popped at done.
module tb_mul_seq;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int checks = 0;
    int passes = 0;
    logic [2*W-1:0] exp_q[$];

    always #5 clk = ~clk;

    mul_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .product(product), .busy(busy), .done(done)
    );

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SIGNED_MUL_EN
        logic signed [2*W-1:0] p;
        p = $signed(x) * $signed(y);
        return p;
`else
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
`endif
    endfunction

    function automatic logic [2*W-1:0] pop_exp();
        return exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    endfunction

    task automatic kick(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    // n counts negedges from the one after the start edge; nb counts busy cycles seen
    task automatic wait_done(output int n, output int nb);
        n = 1;
        nb = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({product, busy, done} !== {32'h0, 2'b00}) $display("FAIL reset_state: product=%h busy=%b done=%b want 0/0/0", product, busy, done);
        else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_idle_hold: busy=%b done=%b want 0/0", busy, done);
        else passes++;
    endtask

    task automatic test_basic();
        int n, nb;
        logic [2*W-1:0] e;
        kick(16'd3, 16'd5);
        checks++;
        if (product !== 32'h0) $display("FAIL basic_hold_in_run: product=%h want 0", product);
        else passes++;
        wait_done(n, nb);
        checks++;
        if (n !== 17) $display("FAIL basic_latency: got %0d want 17", n);
        else passes++;
        checks++;
        if (nb !== 16) $display("FAIL basic_busy_cycles: got %0d want 16", nb);
        else passes++;
        e = pop_exp();
        checks++;
        if (product !== e || product !== 32'h0000000F) $display("FAIL basic_product: got %h want %h", product, e);
        else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || product !== e) $display("FAIL basic_done_pulse: done=%b product=%h want 0/%h", done, product, e);
        else passes++;
    endtask

    task automatic test_extremes();
        int n, nb;
        logic [2*W-1:0] e;
        kick(16'hFFFF, 16'hFFFF);
        wait_done(n, nb);
        e = pop_exp();
        checks++;
        if (product !== e) $display("FAIL max_operands: got %h want %h", product, e);
        else passes++;
        kick(16'h0000, 16'h1234);
        wait_done(n, nb);
        checks++;
        if (n !== 17) $display("FAIL zero_latency: got %0d want 17", n);
        else passes++;
        e = pop_exp();
        checks++;
        if (product !== e) $display("FAIL zero_operand: got %h want %h", product, e);
        else passes++;
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        int at = 0;
        logic [2*W-1:0] e;
        kick(16'd7, 16'd6);
        for (int i = 2; i <= 30; i++) begin
            @(negedge clk);
            if (i == 5) begin
                a = 16'd2;
                b = 16'd2;
                start = 1'b1;
            end
            if (i == 6) start = 1'b0;
            if (done) begin
                pulses++;
                at = i;
                e = pop_exp();
                checks++;
                if (product !== e || product !== 32'h0000002A) $display("FAIL ignore_product: got %h want %h", product, e);
                else passes++;
            end
        end
        checks++;
        if (pulses !== 1 || at !== 17) $display("FAIL ignore_done_pulses: got %0d at %0d want 1 at 17", pulses, at);
        else passes++;
    endtask

    task automatic test_async_reset();
        int n, nb;
        logic [2*W-1:0] e;
        kick(16'd100, 16'd100);
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        void'(exp_q.pop_back());
        #1;
        checks++;
        if ({product, busy, done} !== {32'h0, 2'b00}) $display("FAIL async_reset: product=%h busy=%b done=%b want 0/0/0", product, busy, done);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        kick(16'd10, 16'd10);
        wait_done(n, nb);
        e = pop_exp();
        checks++;
        if (product !== e || product !== 32'h00000064) $display("FAIL after_reset_product: got %h want %h", product, e);
        else passes++;
    endtask

    task automatic test_sign_boundary();
        int n, nb;
        logic [2*W-1:0] e;
        kick(16'hFFFD, 16'd5);
        wait_done(n, nb);
        e = pop_exp();
`ifdef SIGNED_MUL_EN
        checks++;
        if (product !== e || product !== 32'hFFFFFFF1) $display("FAIL neg_times_pos: got %h want FFFFFFF1", product);
        else passes++;
`else
        checks++;
        if (product !== e || product !== 32'h0004FFF1) $display("FAIL neg_times_pos: got %h want 0004FFF1", product);
        else passes++;
`endif
        kick(16'h8000, 16'h8000);
        wait_done(n, nb);
        e = pop_exp();
        checks++;
        if (product !== e || product !== 32'h40000000) $display("FAIL min_times_min: got %h want 40000000", product);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int t0 = 0;
        int t1 = 0;
        int overlap = 0;
        logic [2*W-1:0] e;
        @(negedge clk);
        a = 16'd9;
        b = 16'd11;
        start = 1'b1;
        exp_q.push_back(model(16'd9, 16'd11));
        exp_q.push_back(model(16'd4, 16'd5));
        for (int i = 1; i <= 60 && pulses < 2; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a = 16'd4;
                b = 16'd5;
            end
            if (busy && done) overlap++;
            if (done) begin
                pulses++;
                if (pulses == 1) t0 = i;
                else begin
                    t1 = i;
                    start = 1'b0;
                end
                e = pop_exp();
                checks++;
                if (product !== e) $display("FAIL b2b_product%0d: got %h want %h", pulses, product, e);
                else passes++;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses !== 2 || t1 - t0 !== 18) $display("FAIL b2b_spacing: pulses=%0d gap=%0d want 2/18", pulses, t1 - t0);
        else passes++;
        checks++;
        if (overlap !== 0) $display("FAIL busy_done_overlap: got %0d want 0", overlap);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_ignore_start();
        test_async_reset();
        test_sign_boundary();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
